// File: rtl/conv_enc_213_framer_if.sv
// Handshake bundle for the (2,1,3) framed encoder: din side, code side, frame flags.
// Error-injection controls exist only when CONV_ENC_213_ERR_INJECT_EN is defined.
interface conv_enc_213_framer_if;
   logic       start;
   logic       din;
   logic       din_valid;
   logic       din_ready;
   logic [1:0] code_out;
   logic       code_valid;
   logic       code_ready;
   logic       frame_start;
   logic       frame_end;
   logic       busy;
`ifdef CONV_ENC_213_ERR_INJECT_EN
   logic       err_en;
   logic [8:0] err_index;
   logic [1:0] err_mask;
`endif

   modport master (
      input  start, din, din_valid, code_ready,
`ifdef CONV_ENC_213_ERR_INJECT_EN
      input  err_en, err_index, err_mask,
`endif
      output din_ready, code_out, code_valid, frame_start, frame_end, busy
   );

   modport slave (
      output start, din, din_valid, code_ready,
`ifdef CONV_ENC_213_ERR_INJECT_EN
      output err_en, err_index, err_mask,
`endif
      input  din_ready, code_out, code_valid, frame_start, frame_end, busy
   );
endinterface

// File: rtl/conv_enc_213_framer.sv
// Rate-1/2 (2,1,3) framed convolutional encoder, 1-cycle din->code latency, single output stage
// stalls din_ready while code_valid && !code_ready. Optional CONV_ENC_213_ERR_INJECT_EN adds symbol XOR.
module conv_enc_213_framer #(
   parameter int         FRAME_LEN = 16,
   parameter int         M         = 3,
   parameter logic [3:0] G0        = 4'b1111,
   parameter logic [3:0] G1        = 4'b1101
) (
   input logic                  clock,
   input logic                  reset,
   conv_enc_213_framer_if.master bus
);
   typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

   localparam logic [8:0] LAST_DATA = 9'(FRAME_LEN - 1);
   localparam logic [8:0] LAST_TAIL = 9'(M - 1);

   state_t     state, state_n;
   logic [2:0] sr, sr_n;
   logic [8:0] bit_cnt, cnt_n;
   logic [1:0] code_q, code_n;
   logic       vld_q, vld_n;
   logic       fs_q, fs_n;
   logic       fe_q, fe_n;
   logic       busy_q, busy_n;
   logic       load, step, first, last, din_rdy;
   logic       u;
   logic [3:0] v;
   logic [1:0] sym, sym_out;

   // Tail steps feed zeros so the trellis walks back to state 0.
   assign u    = (state == DATA) ? bus.din : 1'b0;
   assign v    = {u, sr};
   assign sym  = {^(v & G0), ^(v & G1)};
   assign load = !vld_q || bus.code_ready;

`ifdef CONV_ENC_213_ERR_INJECT_EN
   logic       err_en_q;
   logic [8:0] err_idx_q;
   logic [1:0] err_mask_q;
   logic [9:0] sym_idx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_en_q   <= 1'b0;
         err_idx_q  <= '0;
         err_mask_q <= '0;
      end else if (state == IDLE && bus.start) begin
         err_en_q   <= bus.err_en;
         err_idx_q  <= bus.err_index;
         err_mask_q <= bus.err_mask;
      end
   end

   // bit_cnt restarts at 0 in TAIL, so tail symbols sit at FRAME_LEN + bit_cnt.
   assign sym_idx = (state == TAIL) ? (10'(FRAME_LEN) + {1'b0, bit_cnt}) : {1'b0, bit_cnt};
   assign sym_out = (err_en_q && sym_idx == {1'b0, err_idx_q}) ? (sym ^ err_mask_q) : sym;
`else
   assign sym_out = sym;
`endif

   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = bit_cnt;
      code_n  = code_q;
      vld_n   = vld_q;
      fs_n    = fs_q;
      fe_n    = fe_q;
      busy_n  = busy_q;
      din_rdy = 1'b0;
      step    = 1'b0;
      first   = 1'b0;
      last    = 1'b0;
      if (bus.code_ready) vld_n = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            sr_n    = 3'b000;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = DATA;
         end
         DATA: begin
            din_rdy = load;
            if (bus.din_valid && load) begin
               step  = 1'b1;
               first = (bit_cnt == 9'd0);
               if (bit_cnt == LAST_DATA) begin
                  cnt_n   = '0;
                  state_n = TAIL;
               end else begin
                  cnt_n = bit_cnt + 9'd1;
               end
            end
         end
         TAIL: if (load) begin
            step = 1'b1;
            if (bit_cnt == LAST_TAIL) begin
               last    = 1'b1;
               cnt_n   = '0;
               state_n = DRAIN;
            end else begin
               cnt_n = bit_cnt + 9'd1;
            end
         end
         DRAIN: if (vld_q && bus.code_ready) begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (step) begin
         sr_n   = {u, sr[2:1]};
         code_n = sym_out;
         vld_n  = 1'b1;
         fs_n   = first;
         fe_n   = last;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= 3'b000;
         bit_cnt <= '0;
         code_q  <= 2'b00;
         vld_q   <= 1'b0;
         fs_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         sr      <= sr_n;
         bit_cnt <= cnt_n;
         code_q  <= code_n;
         vld_q   <= vld_n;
         fs_q    <= fs_n;
         fe_q    <= fe_n;
         busy_q  <= busy_n;
      end
   end

   assign bus.din_ready   = din_rdy;
   assign bus.code_out    = code_q;
   assign bus.code_valid  = vld_q;
   assign bus.frame_start = fs_q;
   assign bus.frame_end   = fe_q;
   assign bus.busy        = busy_q;
endmodule
